// File: rtl/vram_fetch_arbiter.sv
// vram_fetch_arbiter: shares the single-port VRAM between the CPU bus and the
// video line-fetch path. A trigger pulse bursts one display row into the
// scanline buffer. Video has priority, but during a burst one slot in every
// CPU_SLOT_EVERY cycles goes to a waiting CPU request.
module vram_fetch_arbiter #(
    parameter int WORDS_PER_LINE = 32,
    parameter int LINE_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 13,
    parameter int DATA_WIDTH     = 16,
    parameter int MEM_LATENCY    = 2,
    parameter int CPU_SLOT_EVERY = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    // video side
    input  logic                              i_trigger_read,
    input  logic [LINE_WIDTH-1:0]             i_line,
    output logic                              o_lb_we,
    output logic [$clog2(WORDS_PER_LINE)-1:0] o_lb_waddr,
    output logic [DATA_WIDTH-1:0]             o_lb_wdata,
    output logic                              o_line_done,
    output logic                              o_overrun,
    // CPU side
    input  logic                              i_cpu_req,
    input  logic                              i_cpu_we,
    input  logic [ADDR_WIDTH-1:0]             i_cpu_addr,
    input  logic [DATA_WIDTH-1:0]             i_cpu_wdata,
    output logic                              o_cpu_ack,
    output logic [DATA_WIDTH-1:0]             o_cpu_rdata,
    // VRAM side
    output logic                              o_mem_en,
    output logic                              o_mem_we,
    output logic [ADDR_WIDTH-1:0]             o_mem_addr,
    output logic [DATA_WIDTH-1:0]             o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]             i_mem_rdata
);

    localparam int WIDX_W = $clog2(WORDS_PER_LINE);
    localparam int SLOT_W = (CPU_SLOT_EVERY > 1) ? $clog2(CPU_SLOT_EVERY) : 1;
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS_PER_LINE - 1);
    localparam logic [SLOT_W-1:0] CPU_SLOT  = SLOT_W'(CPU_SLOT_EVERY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Tag travelling alongside each VRAM read until its data returns.
    typedef struct packed {
        logic              valid;
        logic              is_video;
        logic [WIDX_W-1:0] idx;
    } tag_t;

    state_t                  state_q, state_d;
    logic [LINE_WIDTH-1:0]   row_q, row_d;
    logic [WIDX_W-1:0]       word_q, word_d;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic                    cpu_busy_q, cpu_busy_d;
    logic                    overrun_q, overrun_d;
    logic                    line_done_q, line_done_d;
    logic                    cpu_wr_ack_q, cpu_wr_ack_d;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                    mem_en_q, mem_en_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    // Stage 0 lines up with the issue cycle; stage MEM_LATENCY with returning data.
    tag_t                    tag_q [0:MEM_LATENCY];
    tag_t                    tag_d [0:MEM_LATENCY];

    tag_t                    ret_tag;
    logic                    lb_we;
    logic                    cpu_rd_ack;
    logic                    cpu_ack;
    logic                    cpu_pending;
    logic                    video_issue;
    logic                    cpu_issue;
    logic [31:0]             video_addr_full;

    assign ret_tag         = tag_q[MEM_LATENCY];
    assign lb_we           = ret_tag.valid & ret_tag.is_video;
    assign cpu_rd_ack      = ret_tag.valid & ~ret_tag.is_video;
    assign cpu_ack         = cpu_wr_ack_q | cpu_rd_ack;
    assign cpu_pending     = i_cpu_req & ~cpu_busy_q;
    // Row base plus word index; the upper bits fall away when truncated to ADDR_WIDTH.
    assign video_addr_full = 32'(row_q) * 32'(WORDS_PER_LINE) + 32'(word_q);

    // Next-state, arbitration and return-path decode.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        row_d        = row_q;
        word_d       = word_q;
        slot_d       = slot_q;
        cpu_busy_d   = cpu_busy_q;
        overrun_d    = overrun_q;
        line_done_d  = 1'b0;
        cpu_wr_ack_d = mem_en_q & mem_we_q;
        cpu_rdata_d  = cpu_rd_ack ? i_mem_rdata : cpu_rdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        video_issue  = 1'b0;
        cpu_issue    = 1'b0;
        tag_d[0]     = '0;
        for (int k = 1; k <= MEM_LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end

        // The held request is released for re-issue only once its ack is out.
        if (cpu_ack) begin
            cpu_busy_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // A trigger beats a simultaneous CPU request.
                if (i_trigger_read) begin
                    state_d = FETCH;
                    row_d   = i_line;
                    word_d  = '0;
                    slot_d  = '0;
                end else begin
                    cpu_issue = cpu_pending;
                end
            end
            FETCH: begin
                if (i_trigger_read) begin
                    overrun_d = 1'b1;
                end
                slot_d = (slot_q == CPU_SLOT) ? '0 : slot_q + 1'b1;
                if (slot_q == CPU_SLOT && cpu_pending) begin
                    cpu_issue = 1'b1;
                end else begin
                    video_issue = 1'b1;
                    word_d      = word_q + 1'b1;
                    if (word_q == LAST_WORD) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (i_trigger_read) begin
                    overrun_d = 1'b1;
                end
                cpu_issue = cpu_pending;
                if (lb_we && ret_tag.idx == LAST_WORD) begin
                    state_d     = IDLE;
                    line_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (video_issue) begin
            mem_en_d   = 1'b1;
            mem_addr_d = video_addr_full[ADDR_WIDTH-1:0];
            tag_d[0]   = '{valid: 1'b1, is_video: 1'b1, idx: word_q};
        end else if (cpu_issue) begin
            mem_en_d    = 1'b1;
            mem_we_d    = i_cpu_we;
            mem_addr_d  = i_cpu_addr;
            mem_wdata_d = i_cpu_we ? i_cpu_wdata : '0;
            cpu_busy_d  = 1'b1;
            // Writes ack straight from the issue flop; only reads need a tag.
            tag_d[0]    = '{valid: ~i_cpu_we, is_video: 1'b0, idx: '0};
        end
    end

    // State and registered outputs, cleared by synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
        if (!i_rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            word_q       <= '0;
            slot_q       <= '0;
            cpu_busy_q   <= 1'b0;
            overrun_q    <= 1'b0;
            line_done_q  <= 1'b0;
            cpu_wr_ack_q <= 1'b0;
            cpu_rdata_q  <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            // NOTE: the tag pipe is reset (unlike a data RAM) so reads in flight at reset never complete.
            for (int k = 0; k <= MEM_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            word_q       <= word_d;
            slot_q       <= slot_d;
            cpu_busy_q   <= cpu_busy_d;
            overrun_q    <= overrun_d;
            line_done_q  <= line_done_d;
            cpu_wr_ack_q <= cpu_wr_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            for (int k = 0; k <= MEM_LATENCY; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign o_mem_en    = mem_en_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_lb_we     = lb_we;
    assign o_lb_waddr  = lb_we ? ret_tag.idx : '0;
    assign o_lb_wdata  = lb_we ? i_mem_rdata : '0;
    assign o_line_done = line_done_q;
    assign o_overrun   = overrun_q;
    assign o_cpu_ack   = cpu_ack;
    assign o_cpu_rdata = cpu_rd_ack ? i_mem_rdata : cpu_rdata_q;

endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// tb_vram_fetch_arbiter: directed and randomized bursts with CPU traffic,
// checked against a shadow copy of VRAM and the arbitration rules.
module tb_vram_fetch_arbiter;

    localparam int WPL  = 32;
    localparam int LW   = 8;
    localparam int AW   = 13;
    localparam int DW   = 16;
    localparam int ML   = 2;
    localparam int SLOT = 4;

    logic           i_clk = 1'b0;
    logic           i_rst_n;
    logic           i_trigger_read;
    logic [LW-1:0]  i_line;
    logic           o_lb_we;
    logic [4:0]     o_lb_waddr;
    logic [DW-1:0]  o_lb_wdata;
    logic           o_line_done;
    logic           o_overrun;
    logic           i_cpu_req;
    logic           i_cpu_we;
    logic [AW-1:0]  i_cpu_addr;
    logic [DW-1:0]  i_cpu_wdata;
    logic           o_cpu_ack;
    logic [DW-1:0]  o_cpu_rdata;
    logic           o_mem_en;
    logic           o_mem_we;
    logic [AW-1:0]  o_mem_addr;
    logic [DW-1:0]  o_mem_wdata;
    logic [DW-1:0]  i_mem_rdata;

    vram_fetch_arbiter dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_trigger_read (i_trigger_read),
        .i_line         (i_line),
        .o_lb_we        (o_lb_we),
        .o_lb_waddr     (o_lb_waddr),
        .o_lb_wdata     (o_lb_wdata),
        .o_line_done    (o_line_done),
        .o_overrun      (o_overrun),
        .i_cpu_req      (i_cpu_req),
        .i_cpu_we       (i_cpu_we),
        .i_cpu_addr     (i_cpu_addr),
        .i_cpu_wdata    (i_cpu_wdata),
        .o_cpu_ack      (o_cpu_ack),
        .o_cpu_rdata    (o_cpu_rdata),
        .o_mem_en       (o_mem_en),
        .o_mem_we       (o_mem_we),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_rdata    (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // VRAM model: writes land at the edge after issue, reads return ML cycles after issue.
    logic [DW-1:0] vram   [0:(1<<AW)-1];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic [DW-1:0] rd_p0, rd_p1;
    assign i_mem_rdata = rd_p1;

    always @(posedge i_clk) begin
        rd_p1 <= rd_p0;
        rd_p0 <= (o_mem_en && !o_mem_we) ? vram[o_mem_addr] : 'x;
        if (o_mem_en && o_mem_we) vram[o_mem_addr] <= o_mem_wdata;
    end

    typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wd; } iss_t;
    typedef struct { int cyc; logic [4:0] wa; logic [DW-1:0] d; } lb_t;
    typedef struct { int cyc; logic [DW-1:0] d; } ack_t;

    iss_t iss_q[$];
    lb_t  lb_q[$];
    ack_t ack_q[$];
    int   done_q[$];
    int   rst_cyc;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] all_outs();
        return {o_lb_we, o_lb_waddr, o_lb_wdata, o_line_done, o_overrun, o_cpu_ack,
                o_cpu_rdata, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata};
    endfunction

    // Runs ncyc cycles of stimulus, logging every observed event by cycle number.
    task automatic run(input int ncyc, input bit trig, input logic [LW-1:0] row,
                       input int trig2_at, input bit retrig, input int rst_after,
                       input bit cpu_en, input bit cpu_we, input logic [AW-1:0] cpu_addr,
                       input logic [DW-1:0] cpu_wd, input int cpu_at);
        bit retrig_now;
        bit retrig_used;
        bit rst_now;
        retrig_now  = 1'b0;
        retrig_used = 1'b0;
        iss_q.delete(); lb_q.delete(); ack_q.delete(); done_q.delete();
        rst_cyc = -1;
        for (int n = 0; n < ncyc; n++) begin
            i_trigger_read = (trig && n == 0) || (n == trig2_at) || retrig_now;
            if (trig && n == 0) i_line = row;
            retrig_now = 1'b0;
            rst_now = (rst_after > 0) && (rst_cyc < 0) && (iss_q.size() == rst_after);
            i_rst_n = !rst_now;
            if (cpu_en && n == cpu_at) begin
                i_cpu_req   = 1'b1;
                i_cpu_we    = cpu_we;
                i_cpu_addr  = cpu_addr;
                i_cpu_wdata = cpu_we ? cpu_wd : '0;
                if (cpu_we) shadow[cpu_addr] = cpu_wd;
            end
            @(negedge i_clk);
            if (rst_now) begin
                rst_cyc = n;
                check("reset mid-burst outputs zero", all_outs(), '0);
            end
            if (o_mem_en)    iss_q.push_back('{n, o_mem_we, o_mem_addr, o_mem_wdata});
            if (o_lb_we)     lb_q.push_back('{n, o_lb_waddr, o_lb_wdata});
            if (o_cpu_ack) begin
                ack_q.push_back('{n, o_cpu_rdata});
                i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = '0; i_cpu_wdata = '0;
            end
            if (o_line_done) begin
                done_q.push_back(n);
                if (retrig && !retrig_used) begin
                    retrig_now  = 1'b1;
                    retrig_used = 1'b1;
                end
            end
        end
        i_trigger_read = 1'b0;
        i_rst_n        = 1'b1;
    endtask

    // One burst of row `row`, optionally with one CPU op whose address lies outside the row.
    task automatic check_burst(input string tag, input logic [LW-1:0] row, input bit cpu_en,
                               input bit cpu_we, input logic [AW-1:0] cpu_addr,
                               input logic [DW-1:0] cpu_wd);
        iss_t vid[$];
        iss_t cpu[$];
        int   in_burst;
        logic [AW-1:0] ea;
        foreach (iss_q[i]) begin
            if (cpu_en && iss_q[i].addr == cpu_addr) cpu.push_back(iss_q[i]);
            else vid.push_back(iss_q[i]);
        end
        check({tag, " video issue count"}, vid.size(), WPL);
        check({tag, " lb write count"}, lb_q.size(), WPL);
        check({tag, " line_done count"}, done_q.size(), 1);
        in_burst = 0;
        if (cpu.size() == 1 && vid.size() == WPL &&
            cpu[0].cyc > vid[0].cyc && cpu[0].cyc < vid[WPL-1].cyc) in_burst = 1;
        if (vid.size() == WPL && lb_q.size() == WPL) begin
            for (int k = 0; k < WPL; k++) begin
                ea = AW'(int'(row) * WPL + k);
                check($sformatf("%s vaddr[%0d]", tag, k), {vid[k].we, vid[k].addr}, {1'b0, ea});
                check($sformatf("%s lb_waddr[%0d]", tag, k), lb_q[k].wa, k);
                check($sformatf("%s lb_wdata[%0d]", tag, k), lb_q[k].d, shadow[ea]);
                check($sformatf("%s lb latency[%0d]", tag, k), lb_q[k].cyc - vid[k].cyc, ML);
            end
            check({tag, " burst contiguous"}, vid[WPL-1].cyc - vid[0].cyc, WPL - 1 + in_burst);
            if (done_q.size() == 1)
                check({tag, " done after last write"}, done_q[0] - lb_q[WPL-1].cyc, 1);
        end
        if (cpu_en) begin
            check({tag, " cpu issue count"}, cpu.size(), 1);
            check({tag, " cpu ack count"}, ack_q.size(), 1);
            if (cpu.size() == 1 && ack_q.size() == 1) begin
                check({tag, " cpu we/wdata"}, {cpu[0].we, cpu[0].wd}, {cpu_we, cpu_we ? cpu_wd : 16'h0});
                check({tag, " cpu ack latency"}, ack_q[0].cyc - cpu[0].cyc, cpu_we ? 1 : ML);
                if (!cpu_we) check({tag, " cpu rdata"}, ack_q[0].d, shadow[cpu_addr]);
                if (in_burst == 1)
                    check({tag, " cpu reserved slot"}, (cpu[0].cyc - vid[0].cyc) % SLOT, SLOT - 1);
            end
        end else begin
            check({tag, " no cpu ack"}, ack_q.size(), 0);
        end
    endtask

    initial begin
        logic [LW-1:0] row;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        bit            cw;
        for (int i = 0; i < (1 << AW); i++) begin
            shadow[i] = DW'($urandom);
            vram[i]  <= shadow[i];
        end
        i_rst_n = 1'b0; i_trigger_read = 1'b0; i_line = '0;
        i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = '0; i_cpu_wdata = '0;
        repeat (3) @(negedge i_clk);
        check("reset outputs zero", all_outs(), '0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("idle outputs zero", all_outs(), '0);

        // Row 3, no CPU traffic: back-to-back burst.
        run(50, 1'b1, 8'd3, -1, 1'b0, 0, 1'b0, 1'b0, '0, '0, 0);
        check_burst("t1", 8'd3, 1'b0, 1'b0, '0, '0);
        if (iss_q.size() > 0 && done_q.size() > 0)
            check("t1 issue to done", done_q[0] - iss_q[0].cyc, WPL + ML);
        check("t1 no overrun", o_overrun, 1'b0);

        // CPU write then read of 0x0010 while idle.
        run(8, 1'b0, '0, -1, 1'b0, 0, 1'b1, 1'b1, 13'h0010, 16'hBEEF, 0);
        check("t2 write issue count", iss_q.size(), 1);
        check("t2 write ack count", ack_q.size(), 1);
        if (iss_q.size() == 1 && ack_q.size() == 1) begin
            check("t2 write issue", {iss_q[0].we, iss_q[0].addr, iss_q[0].wd}, {1'b1, 13'h0010, 16'hBEEF});
            check("t2 write issued promptly", iss_q[0].cyc <= 1, 1'b1);
            check("t2 write ack latency", ack_q[0].cyc - iss_q[0].cyc, 1);
        end
        run(8, 1'b0, '0, -1, 1'b0, 0, 1'b1, 1'b0, 13'h0010, '0, 0);
        check("t2 read issue count", iss_q.size(), 1);
        check("t2 read ack count", ack_q.size(), 1);
        if (iss_q.size() == 1 && ack_q.size() == 1) begin
            check("t2 read issue", {iss_q[0].we, iss_q[0].addr}, {1'b0, 13'h0010});
            check("t2 read ack latency", ack_q[0].cyc - iss_q[0].cyc, ML);
            check("t2 read data", ack_q[0].d, 16'hBEEF);
        end
        check("t2 rdata held", o_cpu_rdata, 16'hBEEF);

        // Trigger accepted in the line_done cycle: two full bursts, no overrun.
        run(100, 1'b1, 8'd7, -1, 1'b1, 0, 1'b0, 1'b0, '0, '0, 0);
        check("t1b lb count", lb_q.size(), 2 * WPL);
        check("t1b done count", done_q.size(), 2);
        if (lb_q.size() == 2 * WPL)
            check("t1b second row last word", {lb_q[2*WPL-1].wa, lb_q[2*WPL-1].d},
                  {5'(WPL - 1), shadow[AW'(7 * WPL + WPL - 1)]});
        check("t1b no overrun", o_overrun, 1'b0);

        // CPU read raised together with the trigger on row 0: video wins, CPU gets slot 3.
        run(50, 1'b1, 8'd0, -1, 1'b0, 0, 1'b1, 1'b0, 13'h0400, '0, 0);
        check_burst("t3", 8'd0, 1'b1, 1'b0, 13'h0400, '0);
        check("t3 total issues", iss_q.size(), WPL + 1);
        if (iss_q.size() == WPL + 1 && done_q.size() == 1) begin
            check("t3 cpu is 4th issue", iss_q[3].addr, 13'h0400);
            check("t3 burst one cycle longer", done_q[0] - iss_q[0].cyc, WPL + ML + 1);
        end

        // Second trigger 10 cycles into a burst.
        run(60, 1'b1, 8'd42, 10, 1'b0, 0, 1'b0, 1'b0, '0, '0, 0);
        check_burst("t4", 8'd42, 1'b0, 1'b0, '0, '0);
        check("t4 overrun set", o_overrun, 1'b1);
        run(10, 1'b0, '0, -1, 1'b0, 0, 1'b0, 1'b0, '0, '0, 0);
        check("t4 overrun sticky", o_overrun, 1'b1);

        // Reset after 12 words issued: words still in flight are discarded.
        run(40, 1'b1, 8'd5, -1, 1'b0, 12, 1'b0, 1'b0, '0, '0, 0);
        check("t5 reset happened", rst_cyc >= 0, 1'b1);
        check("t5 issues before reset", iss_q.size(), 12);
        check("t5 lb writes before reset", lb_q.size(), 12 - ML);
        check("t5 no line_done", done_q.size(), 0);
        check("t5 no cpu ack", ack_q.size(), 0);
        check("t5 overrun cleared", o_overrun, 1'b0);
        row = LW'($urandom);
        run(50, 1'b1, row, -1, 1'b0, 0, 1'b0, 1'b0, '0, '0, 0);
        check_burst("t5 refetch", row, 1'b0, 1'b0, '0, '0);

        // Top row: addresses 8160..8191 without wrapping.
        run(50, 1'b1, 8'd255, -1, 1'b0, 0, 1'b0, 1'b0, '0, '0, 0);
        check_burst("t6", 8'd255, 1'b0, 1'b0, '0, '0);
        if (iss_q.size() == WPL)
            check("t6 last address", iss_q[WPL-1].addr, 13'd8191);

        // Random rows with one random CPU access at a random point.
        for (int it = 0; it < 8; it++) begin
            row = LW'($urandom);
            cw  = 1'($urandom_range(0, 1));
            cd  = DW'($urandom);
            do ca = AW'($urandom); while (int'(ca) >= int'(row) * WPL && int'(ca) < int'(row) * WPL + WPL);
            run(80, 1'b1, row, -1, 1'b0, 0, 1'b1, cw, ca, cd, $urandom_range(0, 45));
            check_burst($sformatf("rnd%0d", it), row, 1'b1, cw, ca, cd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
